// File: rtl/safe_pkg.sv
// Shared definitions for the safe rotary channel: FSM encodings, phase lookups
// for the quadrature generator, and the default phase dwell.
package safe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } ose_state_e;

  localparam int unsigned DEFAULT_PHASE_TICKS = 4;

  // Phase-to-ab tables, phase 0 in the low pair: up 10,11,01,00; down 01,11,10,00
  localparam logic [7:0] AB_UP_LUT = {2'b00, 2'b01, 2'b11, 2'b10};
  localparam logic [7:0] AB_DN_LUT = {2'b00, 2'b10, 2'b11, 2'b01};

  function automatic logic [1:0] phase_ab(input logic up, input logic [1:0] phase);
    logic [7:0] lut;
    lut = up ? AB_UP_LUT : AB_DN_LUT;
    return lut[{phase, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/ose_phase_timer.sv
// Loadable dwell down-counter; tick is high while the count sits at zero.
module ose_phase_timer
  import safe_pkg::*;
#(
  parameter int unsigned PHASE_TICKS = DEFAULT_PHASE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int unsigned TW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(PHASE_TICKS - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Next count: reload has priority, otherwise count down and stop at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/ose_encoder_gen.sv
// Quadrature rotary emulator: turns an N-detent up/down command into a Gray-coded
// a/b waveform, each phase held PHASE_TICKS cycles, always resting at ab=00.
module ose_encoder_gen
  import safe_pkg::*;
#(
  parameter int unsigned PHASE_TICKS = DEFAULT_PHASE_TICKS,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_valid,
  input  logic             step_up,
  input  logic [CNT_W-1:0] step_count,
  input  logic             abort,
  output logic             step_ready,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_left
);

  ose_state_e       state_q, state_d;
  logic             up_q, up_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             abort_pend_q, abort_pend_d;
  logic             aborted_q, aborted_d;

  logic             timer_load, timer_en, timer_tick;
  logic [CNT_W-1:0] left_dec;
  logic             abort_now;
  logic [1:0]       ab;

  ose_phase_timer #(
    .PHASE_TICKS (PHASE_TICKS)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (timer_en),
    .tick (timer_tick)
  );

  // Sequencing FSM: accept, step through phases, decrement per detent, finish
  always_comb begin
    state_d      = state_q;
    up_d         = up_q;
    phase_d      = phase_q;
    left_d       = left_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
    left_dec     = left_q - 1'b1;
    // an abort arriving on the detent's last cycle counts as already pending
    abort_now    = abort_pend_q | abort;

    unique case (state_q)
      ST_IDLE: begin
        if (step_valid) begin
          up_d         = step_up;
          left_d       = step_count;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          phase_d      = '0;
          if (step_count == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_RUN;
            timer_load = 1'b1;
          end
        end
      end
      ST_RUN: begin
        timer_en     = 1'b1;
        abort_pend_d = abort_now;
        if (timer_tick) begin
          timer_load = 1'b1;
          phase_d    = phase_q + 1'b1;
          if (phase_q == 2'd3) begin
            left_d = left_dec;
            if ((left_dec == '0) || abort_now) begin
              state_d      = ST_FINISH;
              aborted_d    = abort_now && (left_dec != '0);
              abort_pend_d = 1'b0;
            end
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      up_q         <= 1'b0;
      phase_q      <= '0;
      left_q       <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      up_q         <= up_d;
      phase_q      <= phase_d;
      left_q       <= left_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
    end
  end

  // Outputs decode straight from registers so reset forces them immediately
  always_comb begin
    ab = (state_q == ST_RUN) ? phase_ab(up_q, phase_q) : 2'b00;
  end

  assign a          = ab[1];
  assign b          = ab[0];
  assign step_ready = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_FINISH);
  assign aborted    = aborted_q;
  assign steps_left = left_q;

endmodule

// File: tb/tb_ose_encoder_gen.sv
// Directed bench for ose_encoder_gen: one instance with 4-cycle phases, one
// with 1-cycle phases.
module tb_ose_encoder_gen;

  logic       clk;
  logic       rst;

  logic       sv4, up4, ab4_abort;
  logic [7:0] cnt4;
  logic       rdy4, a4, b4, busy4, done4, abd4;
  logic [7:0] left4;

  logic       sv1, up1, abort1;
  logic [7:0] cnt1;
  logic       rdy1, a1, b1, busy1, done1, abd1;
  logic [7:0] left1;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [1:0] up_tab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] dn_tab [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  ose_encoder_gen #(
    .PHASE_TICKS (4),
    .CNT_W       (8)
  ) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .step_valid (sv4),
    .step_up    (up4),
    .step_count (cnt4),
    .abort      (ab4_abort),
    .step_ready (rdy4),
    .a          (a4),
    .b          (b4),
    .busy       (busy4),
    .done       (done4),
    .aborted    (abd4),
    .steps_left (left4)
  );

  ose_encoder_gen #(
    .PHASE_TICKS (1),
    .CNT_W       (8)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .step_valid (sv1),
    .step_up    (up1),
    .step_count (cnt1),
    .abort      (abort1),
    .step_ready (rdy1),
    .a          (a1),
    .b          (b1),
    .busy       (busy1),
    .done       (done1),
    .aborted    (abd1),
    .steps_left (left1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a command on the 4-tick instance and check every cycle to done.
  task automatic run_plain(input string name, input logic up, input int unsigned cnt);
    logic [1:0]  exp_ab;
    logic [1:0]  prev_ab;
    logic [1:0]  cur_ab;
    int unsigned done_seen;
    chk({name, "_ready"}, rdy4, 1);
    sv4  = 1'b1;
    up4  = up;
    cnt4 = cnt[7:0];
    next_cyc();
    sv4 = 1'b0;
    prev_ab   = 2'b00;
    done_seen = 0;
    for (int unsigned i = 1; i <= 16 * cnt; i++) begin
      exp_ab = up ? up_tab[((i - 1) / 4) % 4] : dn_tab[((i - 1) / 4) % 4];
      cur_ab = {a4, b4};
      chk({name, "_ab"}, cur_ab, exp_ab);
      chk({name, "_onebit"}, ($countones(cur_ab ^ prev_ab) <= 1), 1);
      chk({name, "_left"}, left4, cnt - (i - 1) / 16);
      chk({name, "_busy"}, busy4, 1);
      done_seen += done4;
      prev_ab = cur_ab;
      next_cyc();
    end
    chk({name, "_early_done"}, done_seen, 0);
    chk({name, "_done"}, done4, 1);
    chk({name, "_aborted"}, abd4, 0);
    chk({name, "_left_end"}, left4, 0);
    chk({name, "_busy_end"}, busy4, 0);
    chk({name, "_ab_end"}, {a4, b4}, 2'b00);
    chk({name, "_ready_fin"}, rdy4, 0);
    next_cyc();
    chk({name, "_ready_back"}, rdy4, 1);
    chk({name, "_done_gone"}, done4, 0);
  endtask

  initial begin
    logic        got_done;
    int unsigned done_cyc;
    logic        exp_busy;
    logic [1:0]  exp_ab;
    int unsigned ph;

    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    sv4       = 1'b0;
    up4       = 1'b0;
    cnt4      = '0;
    ab4_abort = 1'b0;
    sv1       = 1'b0;
    up1       = 1'b0;
    cnt1      = '0;
    abort1    = 1'b0;

    // Reset state, checked before any clock edge
    #2;
    chk("rst_ab", {a4, b4}, 2'b00);
    chk("rst_ready", rdy4, 1);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_aborted", abd4, 0);
    chk("rst_left", left4, 0);
    chk("rst_ready1", rdy1, 1);
    #10;
    rst = 1'b0;
    next_cyc();
    next_cyc();

    // Two detents up, done at cycle 33
    run_plain("up2", 1'b1, 2);

    // Abort while idle has no effect, then one detent down
    ab4_abort = 1'b1;
    next_cyc();
    ab4_abort = 1'b0;
    chk("idle_abort_busy", busy4, 0);
    run_plain("dn1", 1'b0, 1);

    // Five detents, abort during phase 1 of detent 2
    sv4  = 1'b1;
    up4  = 1'b1;
    cnt4 = 8'd5;
    next_cyc();
    sv4      = 1'b0;
    got_done = 1'b0;
    done_cyc = 0;
    for (int unsigned i = 1; i <= 100 && !got_done; i++) begin
      ab4_abort = (i == 22);
      if (i <= 32) chk("abort_ab", {a4, b4}, up_tab[((i - 1) / 4) % 4]);
      if (done4) begin
        got_done = 1'b1;
        done_cyc = i;
        chk("abort_flag", abd4, 1);
        chk("abort_left", left4, 3);
        chk("abort_ab_end", {a4, b4}, 2'b00);
      end
      next_cyc();
    end
    ab4_abort = 1'b0;
    chk("abort_done_seen", got_done, 1);
    chk("abort_done_cyc", done_cyc, 33);
    for (int unsigned i = 0; i < 8; i++) begin
      chk("abort_no_more_ab", {a4, b4}, 2'b00);
      chk("abort_no_more_busy", busy4, 0);
      next_cyc();
    end
    chk("abort_flag_held", abd4, 1);

    // Zero-count command: finish right away, aborted cleared on accept
    chk("zero_ready", rdy4, 1);
    sv4  = 1'b1;
    cnt4 = 8'd0;
    next_cyc();
    sv4 = 1'b0;
    chk("zero_done", done4, 1);
    chk("zero_aborted", abd4, 0);
    chk("zero_ab", {a4, b4}, 2'b00);
    chk("zero_busy", busy4, 0);
    chk("zero_ready_fin", rdy4, 0);
    chk("zero_left", left4, 0);
    next_cyc();
    chk("zero_ready_back", rdy4, 1);
    chk("zero_done_gone", done4, 0);

    // Asynchronous reset while ab=11
    sv4  = 1'b1;
    up4  = 1'b1;
    cnt4 = 8'd3;
    next_cyc();
    sv4 = 1'b0;
    repeat (5) next_cyc();
    chk("rst_mid_pre_ab", {a4, b4}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rst_mid_ab", {a4, b4}, 2'b00);
    chk("rst_mid_busy", busy4, 0);
    chk("rst_mid_ready", rdy4, 1);
    chk("rst_mid_left", left4, 0);
    #1;
    rst = 1'b0;
    next_cyc();
    run_plain("post_rst", 1'b1, 1);

    // One-tick phases with step_valid held high: 6-cycle command period
    sv1  = 1'b1;
    up1  = 1'b1;
    cnt1 = 8'd1;
    for (int unsigned c = 0; c < 12; c++) begin
      ph       = c % 6;
      exp_busy = (ph >= 1) && (ph <= 4);
      exp_ab   = exp_busy ? up_tab[ph - 1] : 2'b00;
      chk("pt1_ready", rdy1, (ph == 0));
      chk("pt1_busy", busy1, exp_busy);
      chk("pt1_done", done1, (ph == 5));
      chk("pt1_ab", {a1, b1}, exp_ab);
      if (ph == 5) chk("pt1_left", left1, 0);
      next_cyc();
    end
    sv1 = 1'b0;
    chk("pt1_ready_end", rdy1, 1);
    next_cyc();
    chk("pt1_idle_after", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
